mul_div_unit: RTL and testbench

//  Multicycle RV64M multiply/divide unit for the multicycle RISC-V core.

---
 rtl/mul_div_unit.sv | 146 ++++++++++++++
 tb/tb_mul_div_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - radix-2 iterative RV64M multiply/divide unit
// Optional macro MULDIV_EARLY_OUT_EN: also bypass CALC for zero multiplies and small-dividend divides.
module mul_div_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, nextState;

    logic [2:0]        opReg;
    logic [XLEN-1:0]   absA, absB, quo, rem, specialVal;
    logic [2*XLEN-1:0] prod;
    logic [CW-1:0]     counter;
    logic              negRes, bypass;

    logic            aSigned, bSigned, negA, negB, bypassIn;
    logic [XLEN-1:0] absAIn, absBIn, specialIn;

    always_comb begin
        aSigned   = op[2] ? ~op[0] : (op[1:0] == 2'b01 || op[1:0] == 2'b10);
        bSigned   = op[2] ? ~op[0] : (op[1:0] == 2'b01);
        negA      = aSigned & a[XLEN-1];
        negB      = bSigned & b[XLEN-1];
        absAIn    = negA ? -a : a;
        absBIn    = negB ? -b : b;
        bypassIn  = 1'b0;
        specialIn = '0;
        if (op[2] && b == '0) begin
            bypassIn  = 1'b1;
            specialIn = op[1] ? a : '1;
        end else if (op[2] && !op[0] && a == MIN_NEG && b == '1) begin
            bypassIn  = 1'b1;
            specialIn = op[1] ? '0 : a;
        end
`ifdef MULDIV_EARLY_OUT_EN
        else if (!op[2] && (a == '0 || b == '0)) begin
            bypassIn  = 1'b1;
            specialIn = '0;
        end else if (op[2] && absAIn < absBIn) begin
            // quotient is zero and the remainder is the dividend itself
            bypassIn  = 1'b1;
            specialIn = op[1] ? a : '0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_comb begin
        nextState = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) nextState = bypassIn ? FIX : CALC;
            CALC: begin
                busy = 1'b1;
                if (counter == CW'(XLEN-1)) nextState = FIX;
            end
            FIX: begin
                busy      = 1'b1;
                nextState = DONE;
            end
            DONE: begin
                done      = 1'b1;
                nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    logic [XLEN:0]     mulSum, divShift, divDiff;
    logic [2*XLEN-1:0] prodFix;
    logic [XLEN-1:0]   divSel, fixVal;

    always_comb begin
        mulSum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, absA} : '0);
        divShift = {rem, quo[XLEN-1]};
        divDiff  = divShift - {1'b0, absB};
        prodFix  = negRes ? -prod : prod;
        divSel   = opReg[1] ? rem : quo;
        if (bypass)                fixVal = specialVal;
        else if (opReg[2])         fixVal = negRes ? -divSel : divSel;
        else if (opReg[1:0] == '0) fixVal = prodFix[XLEN-1:0];
        else                       fixVal = prodFix[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            opReg      <= '0;
            absA       <= '0;
            absB       <= '0;
            quo        <= '0;
            rem        <= '0;
            prod       <= '0;
            specialVal <= '0;
            counter    <= '0;
            negRes     <= 1'b0;
            bypass     <= 1'b0;
            result     <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    opReg      <= op;
                    absA       <= absAIn;
                    absB       <= absBIn;
                    negRes     <= (op[2] && op[1]) ? negA : (negA ^ negB);
                    bypass     <= bypassIn;
                    specialVal <= specialIn;
                    prod       <= {{XLEN{1'b0}}, absBIn};
                    rem        <= '0;
                    quo        <= absAIn;
                    counter    <= '0;
                end
                CALC: begin
                    counter <= counter + 1'b1;
                    if (!opReg[2]) begin
                        prod <= {mulSum, prod[XLEN-1:1]};
                    end else if (!divDiff[XLEN]) begin
                        rem <= divDiff[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b1};
                    end else begin
                        rem <= divShift[XLEN-1:0];
                        quo <= {quo[XLEN-2:0], 1'b0};
                    end
                end
                FIX: result <= fixVal;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit (XLEN=64)
// Honours MULDIV_EARLY_OUT_EN when the bench and design are built with it.
module tb_mul_div_unit;
    localparam logic [63:0] MINV = 64'h8000_0000_0000_0000;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset, start, busy, done;
    logic [2:0]  op;
    logic [63:0] a, b, result;

    int checks = 0;
    int errors = 0;

    mul_div_unit #(.XLEN(64)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .a(a), .b(b), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] expRes;
        int          expLat;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] absOf(input logic [63:0] v, input logic sgn);
        return (sgn && v[63]) ? -v : v;
    endfunction

    function automatic logic [63:0] refResult(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
        logic [127:0] ex, ey, p;
        logic signed [63:0] sx, sy;
        sx = x;
        sy = y;
        ex = (o == 3'b001 || o == 3'b010) ? {{64{x[63]}}, x} : {64'b0, x};
        ey = (o == 3'b001) ? {{64{y[63]}}, y} : {64'b0, y};
        p  = ex * ey;
        case (o)
            3'b000: return p[63:0];
            3'b001, 3'b010, 3'b011: return p[127:64];
            3'b100: return (y == 0) ? ONES : (x == MINV && y == ONES) ? x : 64'(sx / sy);
            3'b101: return (y == 0) ? ONES : x / y;
            3'b110: return (y == 0) ? x : (x == MINV && y == ONES) ? 64'd0 : 64'(sx % sy);
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic int refLatency(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
        logic sgn;
        sgn = o[2] && !o[0];
        if (o[2] && y == 0) return 2;
        if (sgn && x == MINV && y == ONES) return 2;
`ifdef MULDIV_EARLY_OUT_EN
        if (!o[2] && (x == 0 || y == 0)) return 2;
        if (o[2] && absOf(x, sgn) < absOf(y, sgn)) return 2;
`endif
        return 66;
    endfunction

    // Issues one op and returns its result and latency in edges counted from the start edge.
    task automatic runOp(input logic [2:0] o, input logic [63:0] x, input logic [63:0] y,
                         output logic [63:0] res, output int lat);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        lat = 1;
        #1 start = 1'b0;
        while (1) begin
            @(negedge clk);
            if (done) break;
            if (lat > 200) begin
                checks++; errors++;
                $display("FAIL timeout: no done after %0d edges expected done", lat);
                break;
            end
            @(posedge clk);
            lat++;
        end
        res = result;
    endtask

    localparam int EARLY_LAT = `ifdef MULDIV_EARLY_OUT_EN 2 `else 66 `endif ;

    vec_t vecs[$];
    logic [63:0] res, rx, ry;
    logic [2:0]  ro;
    int lat, cnt;
    bit sawDone;

    initial begin
        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 64'(busy), 64'd0);
        chk("reset done", 64'(done), 64'd0);
        chk("reset result", result, 64'd0);
        reset = 1'b0;

        vecs.push_back('{3'b000, 64'd7, -64'd3, 64'hFFFF_FFFF_FFFF_FFEB, 66});
        vecs.push_back('{3'b011, ONES, ONES, 64'hFFFF_FFFF_FFFF_FFFE, 66});
        vecs.push_back('{3'b001, ONES, ONES, 64'd0, 66});
        vecs.push_back('{3'b100, -64'd7, 64'd2, -64'd3, 66});
        vecs.push_back('{3'b110, -64'd7, 64'd2, -64'd1, 66});
        vecs.push_back('{3'b101, 64'd100, 64'd7, 64'd14, 66});
        vecs.push_back('{3'b111, 64'd100, 64'd7, 64'd2, 66});
        vecs.push_back('{3'b100, 64'd5, 64'd0, ONES, 2});
        vecs.push_back('{3'b110, 64'd5, 64'd0, 64'd5, 2});
        vecs.push_back('{3'b100, MINV, ONES, MINV, 2});
        vecs.push_back('{3'b110, MINV, ONES, 64'd0, 2});
        vecs.push_back('{3'b010, ONES, 64'd2, ONES, 66});
        vecs.push_back('{3'b000, 64'd0, 64'd9, 64'd0, EARLY_LAT});
        vecs.push_back('{3'b101, 64'd3, 64'd8, 64'd0, EARLY_LAT});

        foreach (vecs[i]) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, res, lat);
            chk($sformatf("vec%0d result", i), res, vecs[i].expRes);
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].expLat));
        end

        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            rx = {$urandom, $urandom};
            ry = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: ry = 64'($urandom_range(0, 3)) - 64'd1;
                1: rx = 64'($urandom_range(0, 50));
                2: ry = 64'($urandom_range(1, 1000));
                3: begin rx = MINV; ry = ONES; end
                default: ;
            endcase
            runOp(ro, rx, ry, res, lat);
            chk($sformatf("rand%0d op%0d result", i, ro), res, refResult(ro, rx, ry));
            chk($sformatf("rand%0d op%0d latency", i, ro), 64'(lat), 64'(refLatency(ro, rx, ry)));
        end

        // Re-pulsed start mid-operation must not disturb the first op; start in DONE is ignored.
        @(negedge clk);
        op = 3'b101; a = 64'd100; b = 64'd7; start = 1'b1;
        @(posedge clk);
        cnt = 1;
        #1 start = 1'b0;
        while (cnt < 200) begin
            @(negedge clk);
            if (done) break;
            start = (cnt == 10);
            if (cnt == 10) begin op = 3'b000; a = 64'd3; b = 64'd5; end
            @(posedge clk);
            cnt++;
        end
        chk("repulse latency", 64'(cnt), 64'd66);
        chk("repulse result", result, 64'd14);
        op = 3'b000; a = 64'd3; b = 64'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("start in DONE ignored busy", 64'(busy), 64'd0);
        chk("result held in IDLE", result, 64'd14);
        repeat (3) @(posedge clk);
        #1 chk("result held later", result, 64'd14);

        // Reset mid-operation discards the op.
        @(negedge clk);
        op = 3'b011; a = ONES; b = 64'd3; start = 1'b1;
        @(posedge clk);
        cnt = 1;
        #1 start = 1'b0;
        while (cnt < 30) begin
            @(negedge clk);
            reset = (cnt == 29);
            @(posedge clk);
            cnt++;
        end
        #1;
        chk("midop reset busy", 64'(busy), 64'd0);
        chk("midop reset done", 64'(done), 64'd0);
        chk("midop reset result", result, 64'd0);
        reset = 1'b0;
        sawDone = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (done) sawDone = 1'b1;
        end
        chk("no done after reset", 64'(sawDone), 64'd0);

        runOp(3'b111, 64'd100, 64'd7, res, lat);
        chk("post-reset REMU", res, 64'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
